// File: rtl/qspi_ram_responder_if.sv
// rtl/qspi_ram_responder_if.sv - QSPI pin bundle between bus master and RAM responder
//
// Signals:
//   spi_clk       SCK from master, mode 0 (idle low)
//   spi_select    chip select, active low
//   spi_data_in   IO[3:0] driven by the master
//   spi_data_out  IO[3:0] driven by the responder
//   spi_data_oe   per-line output enable from the responder, 1 = drive
//   busy          responder transaction active
//   cmd_error     one-clock pulse on an unsupported command byte
// Modports:
//   master  drives SCK/select/data_in, observes responder outputs
//   slave   the responder side
interface qspi_ram_responder_if;
    logic       spi_clk;
    logic       spi_select;
    logic [3:0] spi_data_in;
    logic [3:0] spi_data_out;
    logic [3:0] spi_data_oe;
    logic       busy;
    logic       cmd_error;

    modport master (
        output spi_clk,
        output spi_select,
        output spi_data_in,
        input  spi_data_out,
        input  spi_data_oe,
        input  busy,
        input  cmd_error
    );

    modport slave (
        input  spi_clk,
        input  spi_select,
        input  spi_data_in,
        output spi_data_out,
        output spi_data_oe,
        output busy,
        output cmd_error
    );
endinterface

// File: rtl/qspi_ram_responder.sv
// rtl/qspi_ram_responder.sv - quad-SPI responder emulating a small byte-addressed RAM
//
// Supports quad write (0x38) and quad fast read (0xEB) with auto-increment
// addressing that wraps at DEPTH. SCK, select and data are oversampled in the
// system clock domain (clock must be at least 4x SCK).
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   bus        qspi_ram_responder_if.slave (SCK, select, IO lines, busy, cmd_error)
//   txn_count  (only with QSPI_RESP_STATS_EN) saturating count of transactions
//              that ended in READ or WRITE after at least one full data byte
//
// Parameters:
//   DEPTH          bytes of storage, power of two; low log2(DEPTH) address bits used
//   DUMMY_NIBBLES  SCK rising edges ignored between address and read data
//
// Optional feature macro: QSPI_RESP_STATS_EN
module qspi_ram_responder #(
    parameter int DEPTH         = 256,
    parameter int DUMMY_NIBBLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    qspi_ram_responder_if.slave   bus
`ifdef QSPI_RESP_STATS_EN
    ,
    output logic [15:0]           txn_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DUMMY_LAST = (DUMMY_NIBBLES > 0) ? 8'(DUMMY_NIBBLES - 1) : 8'd0;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } state_t;

    // Synchronizers; select resets to its inactive level so a reset never
    // looks like the start of a transaction.
    logic       sck_s1, sck_s2, sck_d;
    logic       sel_s1, sel_s2;
    logic [3:0] din_s1, din_s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_d  <= 1'b0;
            sel_s1 <= 1'b1;
            sel_s2 <= 1'b1;
            din_s1 <= 4'h0;
            din_s2 <= 4'h0;
        end else begin
            sck_s1 <= bus.spi_clk;
            sck_s2 <= sck_s1;
            sck_d  <= sck_s2;
            sel_s1 <= bus.spi_select;
            sel_s2 <= sel_s1;
            din_s1 <= bus.spi_data_in;
            din_s2 <= din_s1;
        end
    end

    logic sck_rise, sck_fall;
    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;

    state_t        state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic [3:0]    nib, nib_n;
    logic [AW-1:0] addr, addr_n;
    logic          wflag, wflag_n;
    logic          rd_lo, rd_lo_n;
    logic          byte_done, byte_done_n;
    logic [3:0]    out_q, out_n;
    logic [3:0]    oe_q, oe_n;
    logic          err_q, err_n;

    logic [7:0]    mem [DEPTH];
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    rd_byte;
    logic [AW+3:0] addr_shift;
    logic [AW-1:0] addr_inc;

    assign rd_byte    = mem[addr];
    assign addr_shift = {addr, din_s2};
    assign addr_inc   = addr + {{(AW-1){1'b0}}, 1'b1};
    assign mem_wdata  = {nib, din_s2};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            nib       <= 4'h0;
            addr      <= '0;
            wflag     <= 1'b0;
            rd_lo     <= 1'b0;
            byte_done <= 1'b0;
            out_q     <= 4'h0;
            oe_q      <= 4'h0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            nib       <= nib_n;
            addr      <= addr_n;
            wflag     <= wflag_n;
            rd_lo     <= rd_lo_n;
            byte_done <= byte_done_n;
            out_q     <= out_n;
            oe_q      <= oe_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        nib_n       = nib;
        addr_n      = addr;
        wflag_n     = wflag;
        rd_lo_n     = rd_lo;
        byte_done_n = byte_done;
        out_n       = out_q;
        oe_n        = oe_q;
        err_n       = 1'b0;
        mem_we      = 1'b0;

        // Deselect wins over any SCK edge seen in the same cycle; a
        // half-received write byte is simply dropped.
        if (state != IDLE && sel_s2) begin
            state_n     = IDLE;
            cnt_n       = 8'd0;
            rd_lo_n     = 1'b0;
            byte_done_n = 1'b0;
            out_n       = 4'h0;
            oe_n        = 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    out_n = 4'h0;
                    oe_n  = 4'h0;
                    if (!sel_s2) begin
                        state_n     = CMD;
                        cnt_n       = 8'd0;
                        wflag_n     = 1'b0;
                        rd_lo_n     = 1'b0;
                        byte_done_n = 1'b0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        if (cnt == 8'd0) begin
                            nib_n = din_s2;
                            cnt_n = 8'd1;
                        end else begin
                            cnt_n = 8'd0;
                            case ({nib, din_s2})
                                8'h38: begin
                                    state_n = ADDR;
                                    wflag_n = 1'b1;
                                end
                                8'hEB: begin
                                    state_n = ADDR;
                                    wflag_n = 1'b0;
                                end
                                default: begin
                                    err_n   = 1'b1;
                                    state_n = IGNORE;
                                end
                            endcase
                        end
                    end
                end
                ADDR: begin
                    // Shift all 24 address bits through; only the low AW survive.
                    if (sck_rise) begin
                        addr_n = addr_shift[AW-1:0];
                        if (cnt == 8'd5) begin
                            cnt_n = 8'd0;
                            if (wflag)
                                state_n = WRITE;
                            else if (DUMMY_NIBBLES > 0)
                                state_n = DUMMY;
                            else
                                state_n = READ;
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise) begin
                        if (cnt == DUMMY_LAST) begin
                            cnt_n   = 8'd0;
                            state_n = READ;
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                end
                READ: begin
                    // The address advances together with the low nibble so the
                    // next high nibble already comes from the following byte.
                    if (sck_fall) begin
                        oe_n = 4'hF;
                        if (!rd_lo) begin
                            out_n   = rd_byte[7:4];
                            rd_lo_n = 1'b1;
                        end else begin
                            out_n       = rd_byte[3:0];
                            rd_lo_n     = 1'b0;
                            addr_n      = addr_inc;
                            byte_done_n = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    oe_n = 4'h0;
                    if (sck_rise) begin
                        if (cnt == 8'd0) begin
                            nib_n = din_s2;
                            cnt_n = 8'd1;
                        end else begin
                            mem_we      = 1'b1;
                            cnt_n       = 8'd0;
                            addr_n      = addr_inc;
                            byte_done_n = 1'b1;
                        end
                    end
                end
                IGNORE: begin
                    out_n = 4'h0;
                    oe_n  = 4'h0;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[addr] <= mem_wdata;
    end

    assign bus.spi_data_out = out_q;
    assign bus.spi_data_oe  = oe_q;
    assign bus.busy         = (state != IDLE);
    assign bus.cmd_error    = err_q;

`ifdef QSPI_RESP_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txn_count <= 16'd0;
        end else if ((state == READ || state == WRITE) && sel_s2 && byte_done
                     && txn_count != 16'hFFFF) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb/tb_qspi_ram_responder.sv - self-checking bench for qspi_ram_responder
module tb_qspi_ram_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    qspi_ram_responder_if bus ();

`ifdef QSPI_RESP_STATS_EN
    logic [15:0] txn_count;
`endif

    qspi_ram_responder #(
        .DEPTH         (256),
        .DUMMY_NIBBLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef QSPI_RESP_STATS_EN
        ,
        .txn_count (txn_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    always @(posedge clock) begin
        if (bus.cmd_error === 1'b1)
            err_pulses++;
    end

    logic [3:0] oe_ctl;
    logic [3:0] oe_data;
    logic [7:0] rd_bytes [4];

    typedef struct {
        logic [23:0] waddr;
        logic [23:0] raddr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One SCK period: data set while SCK low, outputs sampled just before the rise.
    task automatic xfer(input logic [3:0] tx, output logic [3:0] rx, output logic [3:0] oe);
        bus.spi_data_in = tx;
        repeat (4) @(posedge clock);
        #1;
        rx = bus.spi_data_out;
        oe = bus.spi_data_oe;
        bus.spi_clk = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        bus.spi_clk = 1'b0;
    endtask

    task automatic ctl_byte(input logic [7:0] b);
        logic [3:0] rx, oe;
        xfer(b[7:4], rx, oe);
        oe_ctl |= oe;
        xfer(b[3:0], rx, oe);
        oe_ctl |= oe;
    endtask

    task automatic begin_txn(input logic [7:0] cmd, input logic [23:0] a);
        bus.spi_select = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        ctl_byte(cmd);
        ctl_byte(a[23:16]);
        ctl_byte(a[15:8]);
        ctl_byte(a[7:0]);
    endtask

    task automatic end_txn();
        bus.spi_select = 1'b1;
        bus.spi_clk = 1'b0;
        repeat (6) @(posedge clock);
        #1;
    endtask

    task automatic dummies();
        logic [3:0] rx, oe;
        for (int i = 0; i < 4; i++) begin
            xfer(4'h0, rx, oe);
            oe_ctl |= oe;
        end
    endtask

    task automatic read_data(input int n);
        logic [3:0] hi, lo, oe;
        for (int i = 0; i < n; i++) begin
            xfer(4'h0, hi, oe);
            oe_data &= oe;
            xfer(4'h0, lo, oe);
            oe_data &= oe;
            rd_bytes[i] = {hi, lo};
        end
    endtask

    task automatic write_bytes(input logic [23:0] a, input int n, input logic [7:0] b0, input logic [7:0] b1);
        oe_ctl = 4'h0;
        begin_txn(8'h38, a);
        ctl_byte(b0);
        if (n > 1)
            ctl_byte(b1);
        end_txn();
    endtask

    task automatic read_bytes(input logic [23:0] a, input int n);
        oe_ctl  = 4'h0;
        oe_data = 4'hF;
        begin_txn(8'hEB, a);
        dummies();
        read_data(n);
        end_txn();
    endtask

    initial begin
        logic [3:0] rx, oe;
        int p0;
        int cyc;

        vecs[0] = '{waddr: 24'h000040, raddr: 24'h000040, wdata: 8'h5A, exp: 8'h5A};
        vecs[1] = '{waddr: 24'h123441, raddr: 24'h000041, wdata: 8'hC3, exp: 8'hC3};
        vecs[2] = '{waddr: 24'h000042, raddr: 24'hFFFF42, wdata: 8'h00, exp: 8'h00};
        vecs[3] = '{waddr: 24'h000143, raddr: 24'h000043, wdata: 8'hFF, exp: 8'hFF};
        vecs[4] = '{waddr: 24'h0000E7, raddr: 24'h0000E7, wdata: 8'h96, exp: 8'h96};

        bus.spi_clk     = 1'b0;
        bus.spi_select  = 1'b1;
        bus.spi_data_in = 4'h0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_oe", bus.spi_data_oe, 4'h0);
        check("reset_out", bus.spi_data_out, 4'h0);
        check("reset_cmd_error", bus.cmd_error, 1'b0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // Write then read
        write_bytes(24'h000010, 2, 8'hA5, 8'h3C);
        check("wr_oe_idle", oe_ctl, 4'h0);
        read_bytes(24'h000010, 2);
        check("rd_byte0", rd_bytes[0], 8'hA5);
        check("rd_byte1", rd_bytes[1], 8'h3C);
        check("rd_oe_ctl", oe_ctl, 4'h0);
        check("rd_oe_data", oe_data, 4'hF);
        check("rd_oe_after", bus.spi_data_oe, 4'h0);

        // Bad command
        p0 = err_pulses;
        oe_ctl = 4'h0;
        bus.spi_select = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        ctl_byte(8'h9F);
        for (int i = 0; i < 8; i++) begin
            xfer(4'(i + 3), rx, oe);
            oe_ctl |= oe;
        end
        check("bad_busy", bus.busy, 1'b1);
        bus.spi_select = 1'b1;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 10) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("bad_busy_drop", bus.busy, 1'b0);
        check("bad_busy_cycles_le3", (cyc <= 3), 1'b1);
        repeat (4) @(posedge clock);
        #1;
        check("bad_cmd_error_pulses", err_pulses - p0, 1);
        check("bad_oe", oe_ctl, 4'h0);

`ifdef QSPI_RESP_STATS_EN
        check("txn_count", txn_count, 16'd2);
`endif

        // Wrap
        write_bytes(24'h0000FF, 2, 8'h11, 8'h22);
        read_bytes(24'h0000FF, 2);
        check("wrap_rd0", rd_bytes[0], 8'h11);
        check("wrap_rd1", rd_bytes[1], 8'h22);
        read_bytes(24'h000000, 1);
        check("wrap_mem0", rd_bytes[0], 8'h22);

        // Abort mid-byte
        write_bytes(24'h000020, 1, 8'h77, 8'h00);
        oe_ctl = 4'h0;
        begin_txn(8'h38, 24'h000020);
        xfer(4'hE, rx, oe);
        end_txn();
        read_bytes(24'h000020, 1);
        check("abort_keep", rd_bytes[0], 8'h77);

        // Reset mid-read
        oe_ctl  = 4'h0;
        oe_data = 4'hF;
        begin_txn(8'hEB, 24'h000010);
        dummies();
        read_data(1);
        check("rst_pre_byte", rd_bytes[0], 8'hA5);
        check("rst_pre_oe", bus.spi_data_oe, 4'hF);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_oe_async", bus.spi_data_oe, 4'h0);
        check("rst_busy_async", bus.busy, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        bus.spi_select = 1'b1;
        bus.spi_clk = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        read_bytes(24'h000010, 2);
        check("rst_after_rd0", rd_bytes[0], 8'hA5);
        check("rst_after_rd1", rd_bytes[1], 8'h3C);

        // Table-driven single-byte write/read pairs, including address aliasing
        for (int v = 0; v < 5; v++) begin
            write_bytes(vecs[v].waddr, 1, vecs[v].wdata, 8'h00);
            read_bytes(vecs[v].raddr, 1);
            check($sformatf("vec%0d_data", v), rd_bytes[0], vecs[v].exp);
            check($sformatf("vec%0d_oe", v), oe_data, 4'hF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
